icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the single-cycle datapath's instruction port and the memory controller's instruction port. It returns `ihit`/`imemload` from a valid tag match in the same cycle as the request. On a miss it runs a word fetch from memory, then fills the frame. It also keeps hit/miss counters for performance measurement.

## Interface
Parameters:
- SETS, 16, number of frames; must be a power of two ≥ 2; one 32-bit word per frame.

Ports:
- CLK  in  1  clock; rising edge.
- nRST  in  1  asynchronous, active-low reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath instruction byte address; bits [1:0] ignored.
- ihit  out  1  requested word is valid on `imemload` this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory-side read request.
- iaddr  out  32  memory-side word address; bits [1:0] = 0.
- iwait  in  1  memory busy; `iload` is valid in the first cycle with `iREN=1 && iwait=0`.
- iload  in  32  memory read data.
- hit_count  out  32  number of hits; saturates at all-ones.
- miss_count  out  32  number of misses; saturates at all-ones.

## Operation
- Address split, with IDX_W = $clog2(SETS):
  - byte offset = [1:0]
  - index = [IDX_W+1:2]
  - tag = [31:IDX_W+2], TAG_W = 30−IDX_W bits.
- Each frame holds a valid bit, a TAG_W tag and a 32-bit word.
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = `imemREN && valid[idx] && tag[idx]==addr_tag`.
  - `ihit` = hit, combinational.
  - `imemload` = data[idx] on hit, else 0.
  - On `imemREN && !hit`:
    - latch `imemaddr[31:2]` into miss_addr;
    - increment `miss_count` once;
    - go to FETCH.
  - `hit_count` increments on every cycle with hit=1.
- FETCH:
  - Drive `iREN=1` and `iaddr={miss_addr,2'b00}`.
  - `ihit=0` and `imemload=0`.
  - On `iwait=0`, write valid=1, tag and data=`iload` into the frame selected by miss_addr, then go to IDLE.
  - The next IDLE cycle hits if `imemaddr` is unchanged.
- FETCH ignores `imemREN` and `imemaddr`:
  - a dropped request or a changed address does not abort the fill;
  - the fill always completes to the latched address.
- Conflict miss: a fill overwrites the resident frame unconditionally.
- There is no write path and no invalidate port. Self-modifying code is unsupported.
- Counters saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- Reset (async), output values:
  - all valid bits = 0; state = IDLE;
  - `ihit=0`, `imemload=0`;
  - `iREN=0`, `iaddr=0`;
  - `hit_count=0`, `miss_count=0`.
- Tag and data arrays need not be reset.
- Hit latency: 0 cycles, combinational within the request cycle.
- Miss latency: 1 cycle to detect, then N memory wait cycles, then 1 fill-completion edge, then the hit cycle. Total is N+2 cycles from first request to `ihit` (the bench measures exactly N+2).
- `iREN` is registered-state driven, asserted from the cycle after miss detection until the cycle `iwait=0`, inclusive; it deasserts the following cycle.
- Reset asserted during FETCH:
  - the frame is not written;
  - state returns to IDLE;
  - `iREN` drops immediately (async).
- Frame write and lookup of the same index never coincide, because lookups happen only in IDLE.

## Structure
- Add `icachef_t` to `cpu_types_pkg`: packed struct {tag, idx, bytoff}, derived from the default SETS=16 (26/4/2).
- Add `icache_frame_t` to `cpu_types_pkg`: {valid, tag, data}.
- Add the `icache_state_t` enum {IDLE, FETCH} to a new `cache_types_pkg`.
- Port bundling:
  - datapath side maps onto `datapath_cache_if` (cache modport);
  - memory side maps onto `caches_if` (icache modport).
- No sub-module: frame array, FSM and counters stay in one module.

## Test plan
- Cold miss: after reset, request 0x0000_0040 with memory N=2 and iload=0x2001_0005. Required: iREN in cycles 1–3; ihit in cycle 4 with imemload=0x2001_0005; miss_count=1.
- Hit: hold 0x40 for 3 more cycles. Required: ihit=1 each cycle; iREN=0; hit_count=3.
- Conflict: request 0x440, which maps to the same index as 0x40. Required: miss, fill, then hit. A re-request of 0x40 misses again, so miss_count=3.
- Address change in FETCH: miss on 0x80, then switch imemaddr to 0x84 in the same cycle FETCH is entered. Required: iaddr stays 0x80 and frame 0x80 is filled; 0x84 then misses.
- Reset mid-fetch: assert nRST=0 during FETCH. Required: iREN=0 the same cycle; after release a request to the same address misses with counters=0.
- Saturation: force hit_count to 0xFFFF_FFFE and run 3 hits. Required: hit_count=0xFFFF_FFFF.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Cache controller state encodings.
package cache_types_pkg;
   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: word type and the instruction cache address/frame layouts
// for the default 16-frame cache (26-bit tag, 4-bit index, 2-bit byte offset).
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   localparam int ITAG_W = 26;
   localparam int IIDX_W = 4;
   localparam int IBYT_W = 2;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [IBYT_W-1:0] bytoff;
   } icachef_t;

   typedef struct packed {
      logic              valid;
      logic [ITAG_W-1:0] tag;
      word_t             data;
   } icache_frame_t;
endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: combinational hit path, single-word
// miss fetch from memory, and saturating hit/miss counters.
module icache
   import cpu_types_pkg::*;
   import cache_types_pkg::*;
#(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  word_t       imemaddr,
   output logic        ihit,
   output word_t       imemload,
   output logic        iREN,
   output word_t       iaddr,
   input  logic        iwait,
   input  word_t       iload,
   output word_t       hit_count,
   output word_t       miss_count
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_t state_q, state_d;
   logic [29:0]      miss_addr_q, miss_addr_d;
   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   word_t            data_q [SETS];
   word_t            hit_cnt_q, hit_cnt_d;
   word_t            miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             hit, fill;
   logic             unused_byte_off;

   assign req_idx         = imemaddr[IDX_W+1:2];
   assign req_tag         = imemaddr[31:IDX_W+2];
   assign fill_idx        = miss_addr_q[IDX_W-1:0];
   assign fill_tag        = miss_addr_q[29:IDX_W];
   assign unused_byte_off = ^imemaddr[1:0];

   assign hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      ihit        = 1'b0;
      imemload    = '0;
      iREN        = 1'b0;
      iaddr       = '0;
      fill        = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               ihit     = 1'b1;
               imemload = data_q[req_idx];
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            end else if (imemREN) begin
               miss_addr_d = imemaddr[31:2];
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            // The fill always completes to the latched address, whatever the datapath does now.
            iREN  = 1'b1;
            iaddr = {miss_addr_q, 2'b00};
            if (!iwait) begin
               fill    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         valid_q     <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         if (fill) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data need no reset: the valid bits gate them, and fill is low while in reset.
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= iload;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss/hit vector table, then conflict, address
// change during fetch, reset mid-fetch and hit counter saturation sequences.
module tb_icache;
   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int n_checks = 0;
   int n_fail   = 0;
   int mem_wait = 2;
   int wcnt     = 0;

   icache #(.SETS(16)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h2001_0005;
      return {a[15:0], 16'hC0DE} ^ 32'h5A00_0000;
   endfunction

   // Memory model: iREN seen for mem_wait cycles with iwait=1, then one cycle with iwait=0.
   assign iload = mem_word(iaddr);
   always @(posedge CLK) begin
      #1;
      if (iREN) begin
         iwait = (wcnt < mem_wait);
         wcnt++;
      end else begin
         iwait = 1'b1;
         wcnt  = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Requests a, returns cycles until ihit (0 = immediate hit); leaves the request held.
   task automatic access(input logic [31:0] a, input int nw, output int lat);
      mem_wait = nw;
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = a;
      lat      = 0;
      #2;
      while (!ihit && lat < 40) begin
         @(negedge CLK);
         #2;
         lat++;
      end
   endtask

   task automatic idle_cycle();
      @(negedge CLK);
      imemREN = 1'b0;
      #2;
   endtask

   task automatic wait_iren_low(input string name);
      int k;
      k = 0;
      while (iREN && k < 40) begin
         @(negedge CLK);
         #2;
         k++;
      end
      check(name, {31'd0, iREN}, 32'd0);
   endtask

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        exp_hit;
      logic [31:0] exp_load;
      logic        exp_iren;
      logic [31:0] exp_iaddr;
      logic [31:0] exp_hc;
      logic [31:0] exp_mc;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int lat;
      vecs[0] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0,  32'd0, 32'd0};
      vecs[1] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40, 32'd0, 32'd1};
      vecs[2] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40, 32'd0, 32'd1};
      vecs[3] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40, 32'd0, 32'd1};
      vecs[4] = '{1'b1, 32'h40, 1'b1, 32'h2001_0005, 1'b0, 32'h0,  32'd0, 32'd1};
      vecs[5] = '{1'b1, 32'h40, 1'b1, 32'h2001_0005, 1'b0, 32'h0,  32'd1, 32'd1};
      vecs[6] = '{1'b1, 32'h40, 1'b1, 32'h2001_0005, 1'b0, 32'h0,  32'd2, 32'd1};
      vecs[7] = '{1'b0, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0,  32'd3, 32'd1};

      nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1;
      #12;
      check("rst_ihit",  {31'd0, ihit}, 32'd0);
      check("rst_load",  imemload, 32'h0);
      check("rst_iren",  {31'd0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'h0);
      check("rst_hc",    hit_count, 32'h0);
      check("rst_mc",    miss_count, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      // Cold miss with N=2, then hits.
      mem_wait = 2;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         imemREN  = vecs[i].req;
         imemaddr = vecs[i].addr;
         #2;
         check($sformatf("vec%0d_ihit", i),  {31'd0, ihit}, {31'd0, vecs[i].exp_hit});
         check($sformatf("vec%0d_load", i),  imemload, vecs[i].exp_load);
         check($sformatf("vec%0d_iren", i),  {31'd0, iREN}, {31'd0, vecs[i].exp_iren});
         check($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].exp_iaddr);
         check($sformatf("vec%0d_hc", i),    hit_count, vecs[i].exp_hc);
         check($sformatf("vec%0d_mc", i),    miss_count, vecs[i].exp_mc);
      end

      // Conflict miss: 0x440 evicts 0x40, then 0x40 misses again.
      access(32'h440, 1, lat);
      check("conf440_lat", lat, 32'd3);
      check("conf440_load", imemload, mem_word(32'h440));
      idle_cycle();
      access(32'h40, 0, lat);
      check("conf40_lat", lat, 32'd2);
      check("conf40_load", imemload, 32'h2001_0005);
      idle_cycle();
      check("conf_mc", miss_count, 32'd3);
      check("conf_hc", hit_count, 32'd5);

      // Address change while in FETCH.
      mem_wait = 1;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h80;
      #2;
      check("chg_miss80", {31'd0, ihit}, 32'd0);
      @(negedge CLK);
      imemaddr = 32'h84;
      #2;
      check("chg_iren", {31'd0, iREN}, 32'd1);
      check("chg_iaddr", iaddr, 32'h80);
      wait_iren_low("chg_fill80_done");
      check("chg_miss84", {31'd0, ihit}, 32'd0);
      @(negedge CLK);
      imemaddr = 32'h80;
      #2;
      check("chg_fetch84_iaddr", iaddr, 32'h84);
      wait_iren_low("chg_fill84_done");
      check("chg_hit80", {31'd0, ihit}, 32'd1);
      check("chg_load80", imemload, mem_word(32'h80));
      @(negedge CLK);
      imemaddr = 32'h84;
      #2;
      check("chg_hit84", {31'd0, ihit}, 32'd1);
      check("chg_load84", imemload, mem_word(32'h84));
      check("chg_mc", miss_count, 32'd5);
      idle_cycle();

      // Reset asserted mid-fetch.
      mem_wait = 5;
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'hC0;
      @(negedge CLK);
      #2;
      check("rstf_iren_before", {31'd0, iREN}, 32'd1);
      #1 nRST = 1'b0;
      #1;
      check("rstf_iren_async", {31'd0, iREN}, 32'd0);
      check("rstf_iaddr_async", iaddr, 32'h0);
      @(negedge CLK);
      nRST = 1'b1; imemREN = 1'b0;
      #2;
      check("rstf_hc", hit_count, 32'd0);
      check("rstf_mc", miss_count, 32'd0);
      access(32'hC0, 0, lat);
      check("rstf_lat", lat, 32'd2);
      check("rstf_load", imemload, mem_word(32'hC0));
      idle_cycle();
      check("rstf_mc_after", miss_count, 32'd1);
      check("rstf_hc_after", hit_count, 32'd1);

      // Hit counter saturation.
      @(negedge CLK);
      force dut.hit_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.hit_cnt_q;
      #1;
      check("sat_preload", hit_count, 32'hFFFF_FFFE);
      imemREN = 1'b1; imemaddr = 32'hC0;
      #1;
      check("sat_hit", {31'd0, ihit}, 32'd1);
      @(negedge CLK);
      #2;
      check("sat_step1", hit_count, 32'hFFFF_FFFF);
      @(negedge CLK);
      @(negedge CLK);
      imemREN = 1'b0;
      #2;
      check("sat_final", hit_count, 32'hFFFF_FFFF);
      check("sat_mc", miss_count, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no end of test, expected finish before 50000");
      $fatal(1);
   end
endmodule
